// File: rtl/gfx_cmd_dma.sv
// Command-list DMA: fetches COUNT words from shared RAM starting at ADDR and
// streams them out on an AXI-stream master, with CPU-programmable registers.
module gfx_cmd_dma #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned COUNT_W    = 16
) (
  input  logic        clk,
  input  logic        reset_i,
  input  logic        reg_sel_i,
  input  logic        reg_we_i,
  input  logic [1:0]  reg_addr_i,
  input  logic [31:0] reg_data_i,
  output logic [31:0] reg_data_o,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_gnt_i,
  input  logic [31:0] mem_data_i,
  output logic        m_axis_tvalid_o,
  input  logic        m_axis_tready_i,
  output logic [31:0] m_axis_tdata_o,
  output logic        done_o
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned OCC_W = CNT_W + 1;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, ABORT} state_t;

  state_t               state;
  logic [31:0]          addr_reg;
  logic [31:0]          ptr;
  logic [COUNT_W-1:0]   count_reg;
  logic [COUNT_W-1:0]   fetch_left;
  logic [COUNT_W-1:0]   remaining;
  logic                 done;
  logic                 overrun;
  logic                 inflight;
  logic [31:0]          fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     rd_ptr;
  logic [PTR_W-1:0]     wr_ptr;
  logic [CNT_W-1:0]     fifo_count;

  logic busy, wr_addr, wr_count, wr_ctrl, start_req, abort_req, clr_req;
  logic tvalid, beat, accept, push, abort_go, last_beat;
  logic [OCC_W-1:0] occupancy;

  assign busy      = (state != IDLE);
  assign wr_addr   = reg_sel_i && reg_we_i && (reg_addr_i == 2'd0);
  assign wr_count  = reg_sel_i && reg_we_i && (reg_addr_i == 2'd1);
  assign wr_ctrl   = reg_sel_i && reg_we_i && (reg_addr_i == 2'd2);
  assign start_req = wr_ctrl && reg_data_i[0];
  assign abort_req = wr_ctrl && reg_data_i[1];
  assign clr_req   = wr_ctrl && reg_data_i[2];

  assign tvalid    = (fifo_count != '0);
  assign beat      = tvalid && m_axis_tready_i;
  assign occupancy = OCC_W'(fifo_count) + OCC_W'(inflight);
  assign mem_req_o = (state == FETCH) && (fetch_left != '0) &&
                     (occupancy < OCC_W'(FIFO_DEPTH));
  assign accept    = mem_req_o && mem_gnt_i;
  // Read data returning after an abort is dropped rather than buffered.
  assign push      = inflight && (state != ABORT);
  assign abort_go  = abort_req && (state == FETCH || state == DRAIN);
  // The final beat can complete while still in FETCH, so completion is keyed
  // off REMAINING rather than waiting to reach DRAIN first.
  assign last_beat = beat && (remaining == COUNT_W'(1)) &&
                     (state == FETCH || state == DRAIN);

  assign mem_addr_o      = ptr;
  assign m_axis_tvalid_o = tvalid;
  assign m_axis_tdata_o  = fifo_mem[rd_ptr];
  assign done_o          = done;

  always_comb begin
    reg_data_o = '0;
    unique case (reg_addr_i)
      2'd0: reg_data_o = addr_reg;
      2'd1: reg_data_o = 32'(count_reg);
      2'd2: reg_data_o = {29'd0, overrun, done, busy};
      2'd3: reg_data_o = 32'(remaining);
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset_i) begin
      state      <= IDLE;
      addr_reg   <= '0;
      count_reg  <= '0;
      ptr        <= '0;
      fetch_left <= '0;
      remaining  <= '0;
      done       <= 1'b0;
      overrun    <= 1'b0;
      inflight   <= 1'b0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
      fifo_mem   <= '{default: '0};
    end else begin
      if (wr_addr && !busy)  addr_reg  <= {reg_data_i[31:2], 2'b00};
      if (wr_count && !busy) count_reg <= reg_data_i[COUNT_W-1:0];
      if (clr_req) begin
        done    <= 1'b0;
        overrun <= 1'b0;
      end
      if (start_req && !abort_req && busy) overrun <= 1'b1;

      inflight <= accept;
      if (accept) begin
        ptr        <= ptr + 32'd4;
        fetch_left <= fetch_left - COUNT_W'(1);
      end

      if (push) begin
        fifo_mem[wr_ptr] <= mem_data_i;
        wr_ptr           <= wr_ptr + PTR_W'(1);
      end
      if (beat) begin
        rd_ptr    <= rd_ptr + PTR_W'(1);
        remaining <= remaining - COUNT_W'(1);
      end
      if (push && !beat)      fifo_count <= fifo_count + CNT_W'(1);
      else if (!push && beat) fifo_count <= fifo_count - CNT_W'(1);

      unique case (state)
        IDLE: begin
          if (start_req && !abort_req) begin
            done       <= 1'b0;
            ptr        <= addr_reg;
            fetch_left <= count_reg;
            remaining  <= count_reg;
            if (count_reg == '0) done  <= 1'b1;
            else                 state <= FETCH;
          end
        end
        FETCH, DRAIN: begin
          if (abort_go) begin
            state <= ABORT;
            // Flush everything except a head beat already on the bus.
            if (tvalid && !beat) begin
              fifo_count <= CNT_W'(1);
              wr_ptr     <= rd_ptr + PTR_W'(1);
            end else begin
              fifo_count <= '0;
              wr_ptr     <= beat ? rd_ptr + PTR_W'(1) : rd_ptr;
            end
          end else if (last_beat) begin
            state <= IDLE;
            done  <= 1'b1;
          end else if (state == FETCH && fetch_left == '0 && !inflight) begin
            state <= DRAIN;
          end
        end
        ABORT: begin
          if (!inflight && !tvalid) begin
            state     <= IDLE;
            remaining <= '0;
          end
        end
      endcase
    end
  end

  assert property (@(posedge clk) disable iff (reset_i)
    !(push && !beat && fifo_count == CNT_W'(FIFO_DEPTH)));

endmodule

// File: tb/tb_gfx_cmd_dma.sv
// Scoreboard bench for gfx_cmd_dma: expected addresses and stream words are
// queued by the stimulus and consumed by a negedge monitor.
module tb_gfx_cmd_dma;

  logic        clk = 1'b0;
  logic        reset_i;
  logic        reg_sel_i, reg_we_i;
  logic [1:0]  reg_addr_i;
  logic [31:0] reg_data_i, reg_data_o;
  logic        mem_req_o, mem_gnt_i;
  logic [31:0] mem_addr_o, mem_data_i;
  logic        m_axis_tvalid_o, m_axis_tready_i;
  logic [31:0] m_axis_tdata_o;
  logic        done_o;

  gfx_cmd_dma #(.FIFO_DEPTH(4), .COUNT_W(16)) dut (
    .clk(clk), .reset_i(reset_i),
    .reg_sel_i(reg_sel_i), .reg_we_i(reg_we_i), .reg_addr_i(reg_addr_i),
    .reg_data_i(reg_data_i), .reg_data_o(reg_data_o),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_gnt_i(mem_gnt_i),
    .mem_data_i(mem_data_i),
    .m_axis_tvalid_o(m_axis_tvalid_o), .m_axis_tready_i(m_axis_tready_i),
    .m_axis_tdata_o(m_axis_tdata_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_data[$];
  logic [31:0] exp_addr[$];
  logic [31:0] seed = 32'h0;
  int unsigned gnt_mode = 0, rdy_mode = 0;
  bit          tog = 1'b0;
  bit          pend = 1'b0;
  logic [31:0] pend_addr = '0;
  bit          hold_prev = 1'b0, req_wait = 1'b0, done_due = 1'b0, done_arm = 1'b0;
  logic [31:0] held_data = '0, req_addr = '0;
  int          beats_seen = 0, accepts = 0, cyc = 0, first_cyc = 0, last_cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ram_word(input logic [31:0] a);
    return ((a ^ seed) * 32'h9E3779B1) + 32'h12345677;
  endfunction

  function automatic logic pick(input int unsigned m);
    case (m)
      0: return 1'b1;
      1: return tog;
      2: return 1'($urandom_range(0, 1));
      default: return 1'b0;
    endcase
  endfunction

  // Handshake inputs and RAM response, driven just after each rising edge
  always @(posedge clk) begin
    #1;
    tog = ~tog;
    mem_gnt_i = pick(gnt_mode);
    m_axis_tready_i = pick(rdy_mode);
    mem_data_i = pend ? ram_word(pend_addr) : $urandom;
  end

  // Monitor / scoreboard
  always @(negedge clk) begin
    logic [31:0] e;
    cyc++;
    if (reset_i) begin
      hold_prev = 1'b0; req_wait = 1'b0; pend = 1'b0; done_due = 1'b0;
    end else begin
      if (done_due) begin
        chk("done_after_last_beat", 32'(done_o), 32'd1);
        done_due = 1'b0;
      end
      if (hold_prev) begin
        chk("tvalid_held", 32'(m_axis_tvalid_o), 32'd1);
        chk("tdata_held", m_axis_tdata_o, held_data);
      end
      hold_prev = m_axis_tvalid_o && !m_axis_tready_i;
      held_data = m_axis_tdata_o;
      if (m_axis_tvalid_o && m_axis_tready_i) begin
        checks++;
        if (exp_data.size() == 0) begin
          failures++;
          $display("FAIL unexpected_beat: got 0x%08h expected no beat", m_axis_tdata_o);
        end else begin
          e = exp_data.pop_front();
          checks--;
          chk("beat_data", m_axis_tdata_o, e);
        end
        if (beats_seen == 0) first_cyc = cyc;
        last_cyc = cyc;
        beats_seen++;
        if (done_arm && exp_data.size() == 0) done_due = 1'b1;
      end
      if (mem_req_o && req_wait) chk("addr_stable", mem_addr_o, req_addr);
      req_wait = mem_req_o && !mem_gnt_i;
      req_addr = mem_addr_o;
      pend = mem_req_o && mem_gnt_i;
      pend_addr = mem_addr_o;
      if (pend) begin
        accepts++;
        checks++;
        if (exp_addr.size() == 0) begin
          failures++;
          $display("FAIL unexpected_req: got 0x%08h expected no request", mem_addr_o);
        end else begin
          e = exp_addr.pop_front();
          checks--;
          chk("req_addr", mem_addr_o, e);
        end
      end
    end
  end

  task automatic reg_write(input logic [1:0] a, input logic [31:0] d);
    @(posedge clk); #2;
    reg_sel_i = 1'b1; reg_we_i = 1'b1; reg_addr_i = a; reg_data_i = d;
    @(posedge clk); #2;
    reg_sel_i = 1'b0; reg_we_i = 1'b0;
  endtask

  task automatic reg_read(input logic [1:0] a, output logic [31:0] d);
    reg_addr_i = a;
    #1;
    d = reg_data_o;
  endtask

  task automatic xfer_setup(input logic [31:0] a, input int unsigned n);
    seed = $urandom;
    reg_write(2'd0, a);
    reg_write(2'd1, 32'(n));
    for (int unsigned i = 0; i < n; i++) begin
      exp_addr.push_back(a + 32'(4 * i));
      exp_data.push_back(ram_word(a + 32'(4 * i)));
    end
    beats_seen = 0;
    accepts = 0;
  endtask

  task automatic xfer_wait(input int unsigned n, input bit thr);
    logic [31:0] r;
    int unsigned t = 0;
    while (!done_o && t < 4000) begin
      @(posedge clk); #2;
      t++;
    end
    chk("xfer_complete", 32'(done_o), 32'd1);
    @(posedge clk); #2;
    chk("words_left", 32'(exp_data.size()), 32'd0);
    chk("reqs_left", 32'(exp_addr.size()), 32'd0);
    reg_read(2'd3, r); chk("remaining_end", r, 32'd0);
    reg_read(2'd2, r); chk("status_end", r, 32'h2);
    if (thr) chk("throughput", 32'(last_cyc - first_cyc), 32'(n - 1));
    done_arm = 1'b0;
  endtask

  task automatic run_xfer(input logic [31:0] a, input int unsigned n,
                          input int unsigned gm, input int unsigned rm);
    gnt_mode = gm; rdy_mode = rm;
    xfer_setup(a, n);
    done_arm = 1'b1;
    reg_write(2'd2, 32'h1);
    xfer_wait(n, gm == 0 && rm == 0);
  endtask

  initial begin
    logic [31:0] r;
    int unsigned keep, acc_at, since_low, t;
    bit idle_seen;
    reset_i = 1'b1; reg_sel_i = 1'b0; reg_we_i = 1'b0; reg_addr_i = '0; reg_data_i = '0;
    mem_gnt_i = 1'b0; m_axis_tready_i = 1'b0; mem_data_i = '0;
    repeat (3) @(posedge clk);
    #2 reset_i = 1'b0;
    @(posedge clk); #2;

    chk("rst_mem_req", 32'(mem_req_o), 32'd0);
    chk("rst_mem_addr", mem_addr_o, 32'd0);
    chk("rst_tvalid", 32'(m_axis_tvalid_o), 32'd0);
    chk("rst_tdata", m_axis_tdata_o, 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    for (int i = 0; i < 4; i++) begin
      reg_read(2'(i), r);
      chk("rst_reg", r, 32'd0);
    end

    // Basic three-word transfer
    run_xfer(32'h10000100, 3, 0, 0);

    // Zero count
    reg_write(2'd1, 32'd0);
    reg_write(2'd2, 32'h1);
    reg_read(2'd2, r); chk("zero_count_status", r, 32'h2);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #2;
      chk("zero_count_idle", {30'd0, mem_req_o, m_axis_tvalid_o}, 32'd0);
    end

    // Backpressure: the buffer fills and fetching stops
    gnt_mode = 0; rdy_mode = 3;
    xfer_setup(32'h00004000, 8);
    done_arm = 1'b1;
    reg_write(2'd2, 32'h1);
    repeat (20) begin @(posedge clk); #2; end
    chk("bp_reads_issued", 32'(accepts), 32'd4);
    chk("bp_req_low", 32'(mem_req_o), 32'd0);
    chk("bp_tvalid", 32'(m_axis_tvalid_o), 32'd1);
    reg_read(2'd3, r); chk("bp_remaining", r, 32'd8);
    rdy_mode = 0;
    xfer_wait(8, 1'b0);

    // Toggling grant, then address wrap
    run_xfer(32'h00008000, 6, 1, 0);
    run_xfer(32'hFFFFFFF8, 3, 0, 0);

    for (int i = 0; i < 6; i++)
      run_xfer($urandom & 32'hFFFFFFFC, $urandom_range(1, 24),
               $urandom_range(0, 2), $urandom_range(0, 2));

    // Abort mid-transfer with a read in flight
    gnt_mode = 0; rdy_mode = 0;
    xfer_setup(32'h20000000, 16);
    reg_write(2'd2, 32'h1);
    reg_write(2'd2, 32'h1);
    reg_write(2'd0, 32'hDEAD0000);
    t = 0;
    while (beats_seen < 5 && t < 200) begin @(posedge clk); #2; t++; end
    chk("abort_reached_5_beats", 32'(beats_seen >= 5), 32'd1);
    rdy_mode = 3;
    @(posedge clk); #2;
    keep = m_axis_tvalid_o ? 1 : 0;
    chk("abort_read_in_flight", 32'(pend), 32'd1);
    while (exp_data.size() > keep) void'(exp_data.pop_back());
    acc_at = accepts;
    reg_sel_i = 1'b1; reg_we_i = 1'b1; reg_addr_i = 2'd2; reg_data_i = 32'h2;
    @(posedge clk); #2;
    reg_sel_i = 1'b0; reg_we_i = 1'b0;
    repeat (3) begin @(posedge clk); #2; end
    reg_read(2'd2, r); chk("abort_busy_hold", r & 32'h1, 32'(keep));
    rdy_mode = 0;
    since_low = 0; idle_seen = 1'b0; t = 0;
    while (!idle_seen && t < 50) begin
      @(posedge clk); #2;
      t++;
      since_low = m_axis_tvalid_o ? 0 : since_low + 1;
      reg_read(2'd2, r);
      idle_seen = (r[0] == 1'b0);
    end
    chk("abort_idle_latency", 32'(idle_seen && since_low <= 3), 32'd1);
    chk("abort_words_left", 32'(exp_data.size()), 32'd0);
    chk("abort_no_new_reqs", 32'(accepts - acc_at <= 1), 32'd1);
    chk("abort_done", 32'(done_o), 32'd0);
    reg_read(2'd3, r); chk("abort_remaining", r, 32'd0);
    reg_read(2'd2, r); chk("abort_status", r, 32'h4);
    reg_read(2'd0, r); chk("addr_write_ignored", r, 32'h20000000);
    exp_addr.delete();

    // Abort together with start in IDLE does nothing
    reg_write(2'd2, 32'h3);
    reg_read(2'd2, r); chk("abort_start_status", r, 32'h4);
    @(posedge clk); #2;
    chk("abort_start_no_req", 32'(mem_req_o), 32'd0);
    reg_write(2'd2, 32'h4);
    reg_read(2'd2, r); chk("clear_status", r, 32'h0);

    // Reset mid-transfer
    gnt_mode = 0; rdy_mode = 3;
    xfer_setup(32'h00010000, 10);
    reg_write(2'd2, 32'h1);
    repeat (8) begin @(posedge clk); #2; end
    reset_i = 1'b1;
    @(posedge clk); #2;
    chk("mid_rst_req", 32'(mem_req_o), 32'd0);
    chk("mid_rst_tvalid", 32'(m_axis_tvalid_o), 32'd0);
    reset_i = 1'b0;
    exp_data.delete(); exp_addr.delete();
    rdy_mode = 0;
    for (int i = 0; i < 4; i++) begin
      reg_read(2'(i), r);
      chk("mid_rst_reg", r, 32'd0);
    end
    repeat (3) begin @(posedge clk); #2; end
    chk("mid_rst_quiet", {30'd0, mem_req_o, m_axis_tvalid_o}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
